dff_rr_write_sched: RTL and testbench

// - Round-robin scheduler sharing one WIDTH-bit asynchronous-reset D register among N_REQ requesters.
// - Each grant loads the winner's data into the register, then holds it stable for HOLD_CYCLES before the next grant.
// - Sits in front of the DFF datapath and is its only writer.

---
 rtl/dff_rr_write_sched_pkg.sv | 16 +
 rtl/dff_rr_write_sched_if.sv | 25 ++
 rtl/dff_rr_write_sched_rr_pick.sv | 34 +++
 rtl/dff_rr_write_sched.sv | 87 ++++++++
 tb/tb_dff_rr_write_sched.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/dff_rr_write_sched_pkg.sv
// Shared types and helpers for the round-robin write scheduler in front of the shared D register.
package dff_rr_write_sched_pkg;

  localparam int unsigned MAX_REQ = 32;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sched_state_e;

  // One-hot of a requester index; callers truncate to their own N_REQ.
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/dff_rr_write_sched_if.sv
// Requester-side bus of the write scheduler: request/data in, grant and register state out.
interface dff_rr_write_sched_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) ();
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]            req;
  logic [N_REQ-1:0][WIDTH-1:0] data;
  logic [N_REQ-1:0]            gnt;
  logic [WIDTH-1:0]            q;
  logic                        q_valid;
  logic [PW-1:0]               q_owner;
  logic                        busy;

  modport master (
    output req, data,
    input  gnt, q, q_valid, q_owner, busy
  );

  modport slave (
    input  req, data,
    output gnt, q, q_valid, q_owner, busy
  );
endinterface

// File: rtl/dff_rr_write_sched_rr_pick.sv
// Combinational round-robin pick: first set bit of (req & ~mask) scanning from ptr upward, modulo N_REQ.
module dff_rr_write_sched_rr_pick #(
  parameter int N_REQ = 4,
  localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  input  logic [N_REQ-1:0] mask,
  output logic             any,
  output logic [PW-1:0]    idx
);
  logic [N_REQ-1:0]   eff;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [PW:0]        pos;
  logic [PW:0]        sum;

  assign eff = req & ~mask;
  assign any = |eff;

  // Rotate so that requester ptr sits at bit 0, then the lowest set bit is the winner.
  always_comb begin
    dbl = {eff, eff} >> ptr;
    rot = dbl[N_REQ-1:0];
    pos = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) pos = (PW+1)'(k);
    end
    sum = {1'b0, ptr} + pos;
    // Explicit wrap: N_REQ need not be a power of two.
    if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
    idx = sum[PW-1:0];
  end
endmodule

// File: rtl/dff_rr_write_sched.sv
// Round-robin scheduler that is the only writer of a shared WIDTH-bit register; each load is held for HOLD_CYCLES.
module dff_rr_write_sched
  import dff_rr_write_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  dff_rr_write_sched_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  sched_state_e     state, state_d;
  logic [PW-1:0]    ptr, ptr_d;
  logic [CW-1:0]    hold_cnt, cnt_d;
  logic [N_REQ-1:0] gnt_r, gnt_d;
  logic [WIDTH-1:0] q_r;
  logic             qv_r;
  logic [PW-1:0]    own_r;
  logic             load;
  logic             pick_any;
  logic [PW-1:0]    pick_idx;

  // Masking with the live grant keeps a just-served requester out of a back-to-back pick.
  dff_rr_write_sched_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req  (bus.req),
    .ptr  (ptr),
    .mask (gnt_r),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = hold_cnt;
    load    = 1'b0;
    gnt_d   = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          load    = 1'b1;
          gnt_d   = N_REQ'(onehot(32'(pick_idx)));
          ptr_d   = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + PW'(1);
          cnt_d   = CW'(HOLD_CYCLES - 1);
          state_d = (HOLD_CYCLES > 1) ? HOLD : IDLE;
        end
      end
      HOLD: begin
        cnt_d = hold_cnt - CW'(1);
        if (cnt_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt_r    <= '0;
      q_r      <= '0;
      qv_r     <= 1'b0;
      own_r    <= '0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      hold_cnt <= cnt_d;
      gnt_r    <= gnt_d;
      if (load) begin
        q_r   <= bus.data[pick_idx];
        own_r <= pick_idx;
        qv_r  <= 1'b1;
      end
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.q       = q_r;
  assign bus.q_valid = qv_r;
  assign bus.q_owner = own_r;
  assign bus.busy    = (state == HOLD);
endmodule

// File: tb/tb_dff_rr_write_sched.sv
// Bench for dff_rr_write_sched: directed scenarios plus random traffic against a grant-timing reference model.
module tb_dff_rr_write_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dff_rr_write_sched_if #(.N_REQ(4), .WIDTH(8)) ifa ();
  dff_rr_write_sched_if #(.N_REQ(3), .WIDTH(8)) ifb ();

  dff_rr_write_sched #(.N_REQ(4), .WIDTH(8), .HOLD_CYCLES(2)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  dff_rr_write_sched #(.N_REQ(3), .WIDTH(8), .HOLD_CYCLES(1)) u_b (.clk(clk), .rst(rst), .bus(ifb));

  // Model: a grant may happen once HOLD edges have passed since the last one; busy covers the HOLD-1 cycles after it.
  typedef struct {
    int         ptr;
    int         last;
    bit         has;
    int         gidx;
    logic [7:0] q;
    int         owner;
    bit         qv;
    int         cyc;
  } mdl_t;

  mdl_t ma, mb;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset(inout mdl_t m);
    m.ptr = 0; m.last = 0; m.has = 0; m.gidx = -1;
    m.q = 8'h00; m.owner = 0; m.qv = 0;
  endtask

  task automatic mdl_step(inout mdl_t m, input int n, input int hold,
                          input logic [3:0] req, input logic [3:0][7:0] data);
    int gprev;
    int w;
    gprev  = m.gidx;
    w      = -1;
    m.cyc++;
    m.gidx = -1;
    if (!m.has || (m.cyc - m.last >= hold)) begin
      for (int k = 0; k < n; k++) begin
        int i;
        i = (m.ptr + k) % n;
        if (req[i] && i != gprev && w < 0) w = i;
      end
    end
    if (w >= 0) begin
      m.q = data[w]; m.owner = w; m.qv = 1;
      m.ptr = (w + 1) % n; m.last = m.cyc; m.has = 1; m.gidx = w;
    end
  endtask

  task automatic cmp(input string p, input mdl_t m, input int hold, input logic [3:0] gnt,
                     input logic [7:0] q, input logic qv, input logic [1:0] own, input logic busy);
    logic [3:0] eg;
    logic       eb;
    eg = (m.gidx >= 0) ? 4'(1 << m.gidx) : 4'h0;
    eb = m.has && (m.cyc - m.last < hold - 1);
    chk({p, "_gnt"},  32'(gnt),  32'(eg));
    chk({p, "_q"},    32'(q),    32'(m.q));
    chk({p, "_qv"},   32'(qv),   32'(m.qv));
    chk({p, "_own"},  32'(own),  32'(m.owner));
    chk({p, "_busy"}, 32'(busy), 32'(eb));
  endtask

  task automatic cmp_all();
    cmp("a", ma, 2, ifa.gnt, ifa.q, ifa.q_valid, ifa.q_owner, ifa.busy);
    cmp("b", mb, 1, {1'b0, ifb.gnt}, ifb.q, ifb.q_valid, ifb.q_owner, ifb.busy);
  endtask

  task automatic step();
    logic [3:0]      ra, rb;
    logic [3:0][7:0] da, db;
    ra = ifa.req;  da = ifa.data;
    rb = {1'b0, ifb.req};  db = {8'h00, ifb.data};
    @(posedge clk);
    #1;
    mdl_step(ma, 4, 2, ra, da);
    mdl_step(mb, 3, 1, rb, db);
    cmp_all();
  endtask

  // Asserted between edges; outputs are checked before any clock edge arrives.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    mdl_reset(ma);
    mdl_reset(mb);
    cmp_all();
    #3;
    rst = 1'b1;
  endtask

  int owners[$];

  initial begin
    ifa.req = '0; ifa.data = '0;
    ifb.req = '0; ifb.data = '0;
    ma.cyc = 0; mb.cyc = 0;
    mdl_reset(ma); mdl_reset(mb);

    // Reset mid-cycle at 7ns, no edge needed
    #7;
    do_reset();
    chk("t1_q", 32'(ifa.q), 32'h0);
    chk("t1_qv", 32'(ifa.q_valid), 32'h0);
    step(); step();
    chk("t1_gnt_idle", 32'(ifa.gnt), 32'h0);

    // Single requester
    ifa.req = 4'b0010; ifa.data[1] = 8'hA5;
    step();
    chk("t2_q", 32'(ifa.q), 32'hA5);
    chk("t2_gnt", 32'(ifa.gnt), 32'h2);
    chk("t2_own", 32'(ifa.q_owner), 32'h1);
    chk("t2_busy", 32'(ifa.busy), 32'h1);
    ifa.req = 4'b0000;
    step();
    chk("t2_gnt_off", 32'(ifa.gnt), 32'h0);
    chk("t2_busy_off", 32'(ifa.busy), 32'h0);

    // Fairness with all requesting
    do_reset();
    ifa.req = 4'b1111;
    for (int i = 0; i < 4; i++) ifa.data[i] = 8'h10 + 8'(i);
    owners.delete();
    for (int s = 0; s < 10; s++) begin
      step();
      if (ifa.gnt != 4'h0) begin
        owners.push_back(int'(ifa.q_owner));
        chk("t3_q_data", 32'(ifa.q), 32'h10 + 32'(ifa.q_owner));
        chk("t3_spacing", 32'(s % 2), 32'h0);
      end else begin
        chk("t3_q_frozen", 32'(ifa.q), 32'h10 + 32'(ifa.q_owner));
      end
    end
    chk("t3_ngrants", 32'(owners.size()), 32'd5);
    for (int i = 0; i < 5 && i < owners.size(); i++)
      chk("t3_owner", 32'(owners[i]), 32'(i % 4));
    ifa.req = 4'b0000;
    step(); step();

    // Wrap and skip from ptr=3
    do_reset();
    ifa.req = 4'b0100;
    step();
    ifa.req = 4'b0000;
    step();
    chk("t4_ptr3", 32'(u_a.ptr), 32'd3);
    ifa.req = 4'b0101;
    step();
    chk("t4_own0", 32'(ifa.q_owner), 32'd0);
    ifa.req = 4'b0100;
    step();
    step();
    chk("t4_own2", 32'(ifa.q_owner), 32'd2);
    chk("t4_gnt2", 32'(ifa.gnt), 32'h4);
    ifa.req = 4'b0000;
    step();
    chk("t4_ptr_end", 32'(u_a.ptr), 32'd3);

    // Reset mid-HOLD
    ifa.req = 4'b0001; ifa.data[0] = 8'h5A;
    step();
    chk("t5_busy", 32'(ifa.busy), 32'h1);
    do_reset();
    chk("t5_q", 32'(ifa.q), 32'h0);
    chk("t5_qv", 32'(ifa.q_valid), 32'h0);
    ifa.req = 4'b1000; ifa.data[3] = 8'hC3;
    step();
    chk("t5_own3", 32'(ifa.q_owner), 32'd3);
    ifa.req = 4'b0000;
    step();

    // N_REQ=3, HOLD_CYCLES=1: grant every cycle
    do_reset();
    ifb.req = 3'b111;
    for (int i = 0; i < 3; i++) ifb.data[i] = 8'h20 + 8'(i);
    for (int s = 0; s < 4; s++) begin
      step();
      chk("t6_own", 32'(ifb.q_owner), 32'(s % 3));
      chk("t6_gnt", 32'(ifb.gnt), 32'(1 << (s % 3)));
      chk("t6_busy", 32'(ifb.busy), 32'h0);
    end
    ifb.req = 3'b000;
    step();

    // Random traffic
    for (int s = 0; s < 400; s++) begin
      ifa.req  = 4'($urandom);
      ifa.data = 32'($urandom);
      ifb.req  = 3'($urandom);
      ifb.data = 24'($urandom);
      if ($urandom_range(0, 63) == 0) do_reset();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
